// File: rtl/win_pkg.sv
// Shared definitions for the Winograd multiplier datapath: precision codes and the
// operand-pair record carried through the scheduler pipeline.
package win_pkg;

  localparam logic [1:0] BW_16    = 2'b00;
  localparam logic [1:0] BW_8X2   = 2'b11;
  localparam int         ID_MAX_W = 3;

  // id is sized for the largest supported requester count; users slice what they need
  typedef struct packed {
    logic [15:0]         a;
    logic [15:0]         b;
    logic [1:0]          bw;
    logic [ID_MAX_W-1:0] id;
  } mul_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Shared with the tile-buffer read scheduler.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] rotated;
  logic [N-1:0] rot_grant;
  logic         found;

  // Rotate so ptr sits at bit 0, pick the lowest set bit, then rotate back
  assign rotated = N'({req, req} >> ptr);

  always_comb begin
    rot_grant = '0;
    found     = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && rotated[j]) begin
        rot_grant[j] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign grant = N'(({rot_grant, rot_grant} << ptr) >> N);

endmodule

// File: rtl/win_mul_16_signed.sv
// Combinational signed multiplier: one 16x16 product, or two independent 8x8
// products packed as {hi*hi, lo*lo} when bw selects the dual 8-bit mode.
module win_mul_16_signed
  import win_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  bw,
  output logic [31:0] mul_out
);

  logic signed [31:0] a_full, b_full, p_full;
  logic signed [15:0] a_hi, a_lo, b_hi, b_lo, p_hi, p_lo;

  assign a_full = 32'($signed(a));
  assign b_full = 32'($signed(b));
  assign a_hi   = 16'($signed(a[15:8]));
  assign a_lo   = 16'($signed(a[7:0]));
  assign b_hi   = 16'($signed(b[15:8]));
  assign b_lo   = 16'($signed(b[7:0]));

  // Every 8x8 signed product fits in 16 bits, so truncation here is exact
  assign p_full = a_full * b_full;
  assign p_hi   = a_hi * b_hi;
  assign p_lo   = a_lo * b_lo;

  always_comb begin
    mul_out = p_full;
    if (bw == BW_8X2) mul_out = {p_hi, p_lo};
  end

endmodule

// File: rtl/win_mul_rr_sched.sv
// Round-robin scheduler sharing one win_mul_16_signed among N_REQ requesters through
// a 2-stage valid/ready pipeline; products come back tagged with the requester id.
module win_mul_rr_sched
  import win_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*16-1:0] req_a,
  input  logic [N_REQ*16-1:0] req_b,
  input  logic [N_REQ*2-1:0]  req_bw,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ID_W-1:0]     res_id,
  output logic [1:0]          res_bw,
  output logic [31:0]         res_data,
  output logic                busy
);

  logic            s1_v, s2_v;
  logic            s1_en, s2_en;
  mul_req_t        s1_q, sel;
  logic [ID_W-1:0] rr_ptr, grant_id;
  logic [N_REQ-1:0] grant;
  logic [31:0]     mul_out;
  logic            unused_id_bits;

  // Each stage advances whenever the stage ahead is empty or draining this edge
  assign s2_en = !s2_v || res_ready;
  assign s1_en = !s1_v || s2_en;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = grant & {N_REQ{s1_en & !rst}};

  always_comb begin
    sel      = '0;
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel.a    = req_a[16*i +: 16];
        sel.b    = req_b[16*i +: 16];
        sel.bw   = req_bw[2*i +: 2];
        sel.id   = ID_MAX_W'(i);
        grant_id = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_q   <= '0;
      rr_ptr <= '0;
    end else if (s1_en) begin
      s1_v <= |grant;
      s1_q <= sel;
      if (|grant)
        rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  win_mul_16_signed u_mul (
    .a       (s1_q.a),
    .b       (s1_q.b),
    .bw      (s1_q.bw),
    .mul_out (mul_out)
  );

  // S2 doubles as the output register, so it holds steady under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      res_data <= '0;
      res_bw   <= '0;
      res_id   <= '0;
    end else if (s2_en) begin
      s2_v     <= s1_v;
      res_data <= mul_out;
      res_bw   <= s1_q.bw;
      res_id   <= s1_q.id[ID_W-1:0];
    end
  end

  assign unused_id_bits = ^s1_q.id;
  assign res_valid      = s2_v;
  assign busy           = s1_v || s2_v;

endmodule

// File: tb/tb_win_mul_rr_sched.sv
// Scoreboard bench for win_mul_rr_sched: a behavioural pipeline/arbiter model predicts
// req_ready and res_valid each cycle and queues expected products for in-order checking.
module tb_win_mul_rr_sched;
  import win_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid, req_ready;
  logic [N_REQ*16-1:0] req_a, req_b;
  logic [N_REQ*2-1:0]  req_bw;
  logic                res_valid, res_ready;
  logic [ID_W-1:0]     res_id;
  logic [1:0]          res_bw;
  logic [31:0]         res_data;
  logic                busy;

  win_mul_rr_sched #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_bw    (req_bw),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_bw    (res_bw),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      bw;
    logic [31:0]     data;
  } exp_t;

  exp_t             sb[$];
  int               vectors = 0;
  int               miscompares = 0;
  bit               m_s1 = 1'b0, m_s2 = 1'b0;
  int               m_ptr = 0;
  logic [N_REQ-1:0] last_rdy;

  function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b, logic [1:0] bw);
    logic signed [7:0]  ah, al, bh, bl;
    logic signed [15:0] as, bs;
    int p, ph, pl;
    if (bw == BW_8X2) begin
      ah = a[15:8]; al = a[7:0]; bh = b[15:8]; bl = b[7:0];
      ph = int'(ah) * int'(bh);
      pl = int'(al) * int'(bl);
      return {ph[15:0], pl[15:0]};
    end
    as = a; bs = b;
    p = int'(as) * int'(bs);
    return p;
  endfunction

  function automatic logic [N_REQ-1:0] model_grant(logic [N_REQ-1:0] v, int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      int i = (ptr + k) % N_REQ;
      if (v[i]) return N_REQ'(1) << i;
    end
    return '0;
  endfunction

  task automatic set_req(int i, logic [15:0] a, logic [15:0] b, logic [1:0] bw);
    req_valid[i]      = 1'b1;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_bw[2*i +: 2]  = bw;
  endtask

  task automatic set_rand(int i);
    set_req(i, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
  endtask

  // Called just after a negedge with inputs settled; predicts, checks, crosses one posedge
  task automatic step();
    logic [N_REQ-1:0] g, exp_ready;
    bit s1_en, s2_en;
    exp_t e;
    int idx;
    #1;
    g         = model_grant(req_valid, m_ptr);
    s2_en     = !m_s2 || res_ready;
    s1_en     = !m_s1 || s2_en;
    exp_ready = (s1_en && !rst) ? g : '0;
    last_rdy  = req_ready & req_valid;
    vectors++;
    if (req_ready !== exp_ready) begin
      miscompares++;
      $display("[TB] FAIL req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
    end
    vectors++;
    if (res_valid !== m_s2) begin
      miscompares++;
      $display("[TB] FAIL res_valid: got %b expected %b at %0t", res_valid, m_s2, $time);
    end
    vectors++;
    if (busy !== (m_s1 || m_s2)) begin
      miscompares++;
      $display("[TB] FAIL busy: got %b expected %b at %0t", busy, (m_s1 || m_s2), $time);
    end
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_ptr = 0;
      sb.delete();
    end else begin
      if (m_s2 && res_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: result with empty queue at %0t", $time);
        end else begin
          e = sb.pop_front();
          if ({res_id, res_bw, res_data} !== e) begin
            miscompares++;
            $display("[TB] FAIL result: got id=%0d bw=%b data=%h expected id=%0d bw=%b data=%h at %0t",
                     res_id, res_bw, res_data, e.id, e.bw, e.data, $time);
          end
        end
      end
      if (s2_en) m_s2 = m_s1;
      if (s1_en) begin
        m_s1 = |g;
        if (|g) begin
          idx = 0;
          for (int i = 0; i < N_REQ; i++) if (g[i]) idx = i;
          e.id   = ID_W'(idx);
          e.bw   = req_bw[2*idx +: 2];
          e.data = ref_mul(req_a[16*idx +: 16], req_b[16*idx +: 16], req_bw[2*idx +: 2]);
          sb.push_back(e);
          m_ptr = (idx + 1) % N_REQ;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    req_valid = '0;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    res_ready = 1'b1;
    do_reset();
    vectors++;
    if ({res_valid, busy, res_id, res_bw, res_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b busy=%b id=%0d bw=%b data=%h expected all zero",
               res_valid, busy, res_id, res_bw, res_data);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    set_req(0, 16'd3, -16'sd5, BW_16);
    res_ready = 1'b1;
    step();
    vectors++;
    if (last_rdy !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL single_accept: got %b expected 0001", last_rdy);
    end
    req_valid = '0;
    step();
    vectors++;
    if ({res_valid, res_id, res_data} !== {1'b1, 2'd0, 32'hFFFF_FFF1}) begin
      miscompares++;
      $display("[TB] FAIL single_result: got v=%b id=%0d data=%h expected v=1 id=0 data=fffffff1",
               res_valid, res_id, res_data);
    end
    step();
  endtask

  task automatic test_packed();
    set_req(1, 16'h03FE, 16'h0502, BW_8X2);
    step();
    req_valid = '0;
    step();
    vectors++;
    if ({res_valid, res_id, res_bw, res_data} !== {1'b1, 2'd1, 2'b11, 32'h000F_FFFC}) begin
      miscompares++;
      $display("[TB] FAIL packed_result: got v=%b id=%0d bw=%b data=%h expected v=1 id=1 bw=11 data=000ffffc",
               res_valid, res_id, res_bw, res_data);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] exp_g;
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_rand(i);
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_g = N_REQ'(1) << (k % N_REQ);
      vectors++;
      if (last_rdy !== exp_g) begin
        miscompares++;
        $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, last_rdy, exp_g);
      end
      for (int i = 0; i < N_REQ; i++) if (last_rdy[i]) set_rand(i);
    end
    drain();
  endtask

  task automatic test_stall();
    int accepts = 0;
    logic [35:0] held;
    for (int i = 0; i < N_REQ; i++) set_rand(i);
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      accepts += $countones(last_rdy);
      for (int i = 0; i < N_REQ; i++) if (last_rdy[i]) set_rand(i);
      if (k == 1) held = {res_id, res_bw, res_data};
      if (k > 1) begin
        vectors++;
        if ({res_id, res_bw, res_data} !== held) begin
          miscompares++;
          $display("[TB] FAIL stall_hold: got %h expected %h", {res_id, res_bw, res_data}, held);
        end
      end
    end
    vectors++;
    if (accepts != 2) begin
      miscompares++;
      $display("[TB] FAIL stall_accepts: got %0d expected 2", accepts);
    end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      for (int i = 0; i < N_REQ; i++) if (last_rdy[i]) set_rand(i);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < N_REQ; i++) set_rand(i);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      for (int i = 0; i < N_REQ; i++) if (last_rdy[i]) set_rand(i);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '0;
    vectors++;
    if ({res_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL flush: got res_valid=%b busy=%b expected 0 0", res_valid, busy);
    end
    drain();
  endtask

  task automatic test_ptr_wrap();
    set_req(2, 16'h7FFF, 16'h8000, 2'b01);
    step();
    req_valid = '0;
    step();
    set_req(2, 16'hFFFF, 16'hFFFF, 2'b10);
    step();
    vectors++;
    if (last_rdy !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL ptr3_grant: got %b expected 0100", last_rdy);
    end
    set_req(3, 16'h1234, 16'h0010, BW_16);
    set_req(0, 16'h0001, 16'h0002, BW_16);
    req_valid[2] = 1'b0;
    step();
    vectors++;
    if (last_rdy !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL ptr_after_req2: got %b expected 1000", last_rdy);
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 10000; k++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_rand(i);
      step();
      for (int i = 0; i < N_REQ; i++) if (last_rdy[i]) req_valid[i] = 1'b0;
    end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_bw    = '0;
    res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_packed();
    test_round_robin();
    test_stall();
    test_flush();
    test_ptr_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
